// File: rtl/riscv_apb_arbiter.sv
// riscv_apb_arbiter
//   Shares the single memory APB port between the instruction fetch unit (IF)
//   and the load/store unit (LSU). The winning request is replayed on the
//   memory side as SETUP/ACCESS. pready/prdata are returned only to the
//   winner. One transfer is in flight at a time, and an IDLE cycle separates
//   consecutive transfers. Arbitration happens in that IDLE cycle.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : ties go to the port not granted last (IF if none granted yet)
//   undefined : fixed priority, LSU_PRIO=1 -> LSU wins ties, 0 -> IF wins ties
//
// Ports
//   clk, reset                      clock, async active-high reset
//   if_*_i / lsu_*_i                requester APB slave inputs (psel, penable,
//                                   paddr, pwrite, pwdata)
//   if_pready_o, if_prdata_o        IF completion and read data
//   lsu_pready_o, lsu_prdata_o      LSU completion and read data
//   psel_o, penable_o, paddr_o,
//   pwrite_o, pwdata_o              memory-side APB master outputs
//   pready_i, prdata_i              memory-side APB responses
//   gnt_lsu_o                       current/last grant (1 = LSU, 0 = IF)
module riscv_apb_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter bit          LSU_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  // IF requester
  input  logic              if_psel_i,
  input  logic              if_penable_i,
  input  logic [ADDR_W-1:0] if_paddr_i,
  input  logic              if_pwrite_i,
  input  logic [DATA_W-1:0] if_pwdata_i,
  output logic              if_pready_o,
  output logic [DATA_W-1:0] if_prdata_o,
  // LSU requester
  input  logic              lsu_psel_i,
  input  logic              lsu_penable_i,
  input  logic [ADDR_W-1:0] lsu_paddr_i,
  input  logic              lsu_pwrite_i,
  input  logic [DATA_W-1:0] lsu_pwdata_i,
  output logic              lsu_pready_o,
  output logic [DATA_W-1:0] lsu_prdata_o,
  // memory side
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  output logic              gnt_lsu_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   gnt_q, gnt_d;
  logic   win_lsu_c;
  logic   busy_c;
  logic   done_c;

  // Requester penable carries no sequencing information here.
  logic   unused_c;
  assign unused_c = ^{if_penable_i, lsu_penable_i, LSU_PRIO};

`ifdef ARB_ROUND_ROBIN_EN
  // Set once any grant has been made, so the first tie after reset goes to IF.
  logic   gnt_vld_q, gnt_vld_d;
`endif

  // State and grant registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_vld_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
`ifdef ARB_ROUND_ROBIN_EN
      gnt_vld_q <= gnt_vld_d;
`endif
    end
  end

  // Winner selection among the currently asserted requests.
  always_comb begin
    win_lsu_c = lsu_psel_i;
    if (if_psel_i && lsu_psel_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_lsu_c = gnt_vld_q ? ~gnt_q : 1'b0;
`else
      win_lsu_c = LSU_PRIO;
`endif
    end
  end

  // Next-state logic; grant is captured only in IDLE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    gnt_vld_d = gnt_vld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_psel_i || lsu_psel_i) begin
          state_d   = ST_SETUP;
          gnt_d     = win_lsu_c;
`ifdef ARB_ROUND_ROBIN_EN
          gnt_vld_d = 1'b1;
`endif
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Memory-side outputs muxed from the granted port; zero while idle.
  always_comb begin
    busy_c    = (state_q != ST_IDLE);
    done_c    = (state_q == ST_ACCESS) && pready_i;
    psel_o    = busy_c;
    penable_o = (state_q == ST_ACCESS);
    paddr_o   = '0;
    pwrite_o  = 1'b0;
    pwdata_o  = '0;
    if (busy_c) begin
      paddr_o  = gnt_q ? lsu_paddr_i  : if_paddr_i;
      pwrite_o = gnt_q ? lsu_pwrite_i : if_pwrite_i;
      pwdata_o = gnt_q ? lsu_pwdata_i : if_pwdata_i;
    end
  end

  // Completion routed only to the winner; read data zeroed when not ready.
  assign if_pready_o  = done_c && !gnt_q;
  assign lsu_pready_o = done_c &&  gnt_q;
  assign if_prdata_o  = if_pready_o  ? prdata_i : '0;
  assign lsu_prdata_o = lsu_pready_o ? prdata_i : '0;
  assign gnt_lsu_o    = gnt_q;

endmodule

// File: tb/tb_riscv_apb_arbiter.sv
// Testbench for riscv_apb_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transfer-level reference model.
module tb_riscv_apb_arbiter;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam bit          LSU_PRIO = 1'b1;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_psel_i, if_penable_i, if_pwrite_i;
  logic [ADDR_W-1:0] if_paddr_i;
  logic [DATA_W-1:0] if_pwdata_i, if_prdata_o;
  logic              if_pready_o;
  logic              lsu_psel_i, lsu_penable_i, lsu_pwrite_i;
  logic [ADDR_W-1:0] lsu_paddr_i;
  logic [DATA_W-1:0] lsu_pwdata_i, lsu_prdata_o;
  logic              lsu_pready_o;
  logic              psel_o, penable_o, pwrite_o, pready_i, gnt_lsu_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o, prdata_i;

  always #5 clk = ~clk;

  riscv_apb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LSU_PRIO(LSU_PRIO)) dut (
    .clk(clk), .reset(reset),
    .if_psel_i(if_psel_i), .if_penable_i(if_penable_i), .if_paddr_i(if_paddr_i),
    .if_pwrite_i(if_pwrite_i), .if_pwdata_i(if_pwdata_i),
    .if_pready_o(if_pready_o), .if_prdata_o(if_prdata_o),
    .lsu_psel_i(lsu_psel_i), .lsu_penable_i(lsu_penable_i), .lsu_paddr_i(lsu_paddr_i),
    .lsu_pwrite_i(lsu_pwrite_i), .lsu_pwdata_i(lsu_pwdata_i),
    .lsu_pready_o(lsu_pready_o), .lsu_prdata_o(lsu_prdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .paddr_o(paddr_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pready_i(pready_i), .prdata_i(prdata_i), .gnt_lsu_o(gnt_lsu_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester-side intent (held stable while a request is pending).
  logic        r_if_req = 1'b0, r_lsu_req = 1'b0, r_lsu_write = 1'b0;
  logic [31:0] r_if_addr = '0, r_if_wdata = '0, r_lsu_addr = '0, r_lsu_wdata = '0;
  logic [31:0] mem_rdata = '0;
  int          next_stall = 0;

  // Reference model: one transfer record (owner, phase, remaining wait states).
  bit m_busy = 0, m_acc = 0, m_owner = 0, m_has_last = 0;
  int m_stall = 0;

  bit          if_served = 0, lsu_served = 0;
  logic [31:0] if_rdata_seen = '0, lsu_rdata_seen = '0;
  int          if_done_cyc = 0, lsu_done_cyc = 0;
  int          serve_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Tie rule taken straight from the arbitration policy.
  function automatic bit pick_winner(input bit ir, input bit lr);
    if (ir && lr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return m_has_last ? !m_owner : 1'b0;
`else
      return LSU_PRIO;
`endif
    end
    return lr;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step();
    logic [31:0] e_addr, e_wdata;
    bit          e_write, e_if_rdy, e_lsu_rdy;
    if_psel_i     = r_if_req;
    if_paddr_i    = r_if_addr;
    if_pwrite_i   = 1'b0;
    if_pwdata_i   = r_if_wdata;
    if_penable_i  = 1'($urandom_range(0, 1));
    lsu_psel_i    = r_lsu_req;
    lsu_paddr_i   = r_lsu_addr;
    lsu_pwrite_i  = r_lsu_write;
    lsu_pwdata_i  = r_lsu_wdata;
    lsu_penable_i = 1'($urandom_range(0, 1));
    pready_i      = (m_busy && m_acc) ? (m_stall == 0) : 1'($urandom_range(0, 1));
    prdata_i      = mem_rdata;
    #1;
    e_addr    = !m_busy ? 32'h0 : (m_owner ? r_lsu_addr  : r_if_addr);
    e_wdata   = !m_busy ? 32'h0 : (m_owner ? r_lsu_wdata : r_if_wdata);
    e_write   = m_busy && m_owner && r_lsu_write;
    e_if_rdy  = m_busy && m_acc && pready_i && !m_owner;
    e_lsu_rdy = m_busy && m_acc && pready_i &&  m_owner;
    check_eq("psel",      64'(psel_o),       64'(m_busy));
    check_eq("penable",   64'(penable_o),    64'(m_busy && m_acc));
    check_eq("paddr",     64'(paddr_o),      64'(e_addr));
    check_eq("pwrite",    64'(pwrite_o),     64'(e_write));
    check_eq("pwdata",    64'(pwdata_o),     64'(e_wdata));
    check_eq("if_pready", 64'(if_pready_o),  64'(e_if_rdy));
    check_eq("lsu_pready",64'(lsu_pready_o), 64'(e_lsu_rdy));
    check_eq("gnt_lsu",   64'(gnt_lsu_o),    64'(m_owner));
    if (e_if_rdy) begin
      check_eq("if_prdata", 64'(if_prdata_o), 64'(mem_rdata));
      if_served = 1; if_rdata_seen = if_prdata_o; if_done_cyc = cyc;
      serve_q.push_back(0);
    end
    if (e_lsu_rdy) begin
      check_eq("lsu_prdata", 64'(lsu_prdata_o), 64'(mem_rdata));
      lsu_served = 1; lsu_rdata_seen = lsu_prdata_o; lsu_done_cyc = cyc;
      serve_q.push_back(1);
    end
    if (m_busy) begin
      if (m_acc) begin
        if (pready_i) m_busy = 0;
        else          m_stall--;
      end else begin
        m_acc = 1;
      end
    end else if (if_psel_i || lsu_psel_i) begin
      m_owner    = pick_winner(if_psel_i, lsu_psel_i);
      m_busy     = 1;
      m_acc      = 0;
      m_has_last = 1;
      m_stall    = next_stall;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Reset with both requesters asserting: every output must read 0.
  task automatic apply_reset(input string tag);
    r_if_req = 0; r_lsu_req = 0;
    reset = 1'b1;
    if_psel_i = 1'b1; lsu_psel_i = 1'b1; pready_i = 1'b1; prdata_i = 32'hFFFF_FFFF;
    #1;
    check_eq({tag, "_psel"},    64'(psel_o),    64'd0);
    check_eq({tag, "_penable"}, 64'(penable_o), 64'd0);
    check_eq({tag, "_gnt"},     64'(gnt_lsu_o), 64'd0);
    check_eq({tag, "_outs"},    64'({if_pready_o, lsu_pready_o, pwrite_o}), 64'd0);
    check_eq({tag, "_data"},    64'(paddr_o | pwdata_o | if_prdata_o | lsu_prdata_o), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_psel_edge"}, 64'(psel_o), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_busy = 0; m_acc = 0; m_owner = 0; m_has_last = 0; m_stall = 0;
    if_served = 0; lsu_served = 0;
    serve_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int start;
    int n_if, n_lsu;
    int exp_order[$];
    reset = 1'b1;
    if_psel_i = 0; if_penable_i = 0; if_paddr_i = '0; if_pwrite_i = 0; if_pwdata_i = '0;
    lsu_psel_i = 0; lsu_penable_i = 0; lsu_paddr_i = '0; lsu_pwrite_i = 0; lsu_pwdata_i = '0;
    pready_i = 0; prdata_i = '0;
    @(negedge clk);
    apply_reset("rst0");

    // IF read, zero wait states: pready and data two cycles after psel.
    r_if_req = 1; r_if_addr = 32'h8000_0000; r_if_wdata = 32'h0;
    mem_rdata = 32'h0000_0013; next_stall = 0; start = cyc;
    for (int i = 0; i < 10 && !if_served; i++) step();
    r_if_req = 0;
    check_eq("t2_served",  64'(if_served), 64'd1);
    check_eq("t2_latency", 64'(if_done_cyc - start), 64'd2);
    check_eq("t2_rdata",   64'(if_rdata_seen), 64'h13);
    step(); step();

    // LSU write with two wait states.
    if_served = 0; lsu_served = 0;
    r_lsu_req = 1; r_lsu_write = 1; r_lsu_addr = 32'h1000_0004; r_lsu_wdata = 32'hDEAD_BEEF;
    next_stall = 2; start = cyc;
    for (int i = 0; i < 12 && !lsu_served; i++) step();
    r_lsu_req = 0; r_lsu_write = 0;
    check_eq("t3_served",  64'(lsu_served), 64'd1);
    check_eq("t3_latency", 64'(lsu_done_cyc - start), 64'd4);
    check_eq("t3_no_if",   64'(if_served), 64'd0);
    step(); step();

    // Reset while an LSU transfer is stalled in ACCESS.
    r_lsu_req = 1; r_lsu_addr = 32'h2000_0000; next_stall = 5;
    for (int i = 0; i < 10 && !(m_busy && m_acc); i++) step();
    check_eq("t1_in_access", 64'(penable_o), 64'd1);
    apply_reset("rst_mid");
    step();

    // Simultaneous requests, each port drops its request once served.
    apply_reset("rst4");
    r_if_req = 1; r_if_addr = 32'h8000_0100;
    r_lsu_req = 1; r_lsu_addr = 32'h1000_0100; r_lsu_write = 0;
    next_stall = 1;
    for (int i = 0; i < 30 && serve_q.size() < 2; i++) begin
      step();
      if (if_served)  r_if_req  = 0;
      if (lsu_served) r_lsu_req = 0;
    end
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1};
`else
    exp_order = '{1, 0};
`endif
    check_eq("t4_count", 64'(serve_q.size()), 64'd2);
    for (int i = 0; i < 2 && i < serve_q.size(); i++)
      check_eq($sformatf("t4_order%0d", i), 64'(serve_q[i]), 64'(exp_order[i]));
    step(); step();
    check_eq("t4_one_each", 64'(serve_q.size()), 64'd2);

    // Both ports requesting continuously for six transfers.
    apply_reset("rst5");
    r_if_req = 1; r_lsu_req = 1; r_lsu_write = 0; next_stall = 0;
    for (int i = 0; i < 60 && serve_q.size() < 6; i++) begin
      step();
      if (if_served)  begin if_served  = 0; r_if_addr  = $urandom; end
      if (lsu_served) begin lsu_served = 0; r_lsu_addr = $urandom; end
    end
    check_eq("t5_count", 64'(serve_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < serve_q.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check_eq($sformatf("t5_grant%0d", i), 64'(serve_q[i]), 64'(i % 2));
`else
      check_eq($sformatf("t5_grant%0d", i), 64'(serve_q[i]), 64'd1);
`endif
    end
    r_if_req = 0; r_lsu_req = 0;
    step(); step(); step();

    // Random traffic with 0-5 wait states and occasional withdrawals.
    apply_reset("rst6");
    n_if = 0; n_lsu = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!r_if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          r_if_req = 1; r_if_addr = $urandom; r_if_wdata = $urandom;
        end
      end else if (!(m_busy && !m_owner) && $urandom_range(0, 19) == 0) begin
        r_if_req = 0;
      end
      if (!r_lsu_req) begin
        if ($urandom_range(0, 2) == 0) begin
          r_lsu_req = 1; r_lsu_addr = $urandom; r_lsu_wdata = $urandom;
          r_lsu_write = 1'($urandom_range(0, 1));
        end
      end else if (!(m_busy && m_owner) && $urandom_range(0, 19) == 0) begin
        r_lsu_req = 0;
      end
      next_stall = $urandom_range(0, 5);
      mem_rdata  = $urandom;
      step();
      if (if_served)  begin if_served  = 0; r_if_req  = 0; n_if++;  end
      if (lsu_served) begin lsu_served = 0; r_lsu_req = 0; n_lsu++; end
    end
    check_eq("rand_if_activity",  64'(n_if  > 0), 64'd1);
    check_eq("rand_lsu_activity", 64'(n_lsu > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
